// File: rtl/accumulator.sv
// Streaming accumulator: sums NP consecutive NC-lane signed term vectors
// and presents one registered sum vector per batch on a valid/ready port.
module accumulator #(
    parameter int NP = 5,
    parameter int NC = 6,
    parameter int WV = 4
) (
    input  logic                             iCLK,
    input  logic                             iRST,
    input  logic                             iValid_AS_Term,
    output logic                             oReady_AS_Term,
    input  logic [NC*WV-1:0]                 iData_AS_Term,
    output logic                             oValid_BM_Accum,
    input  logic                             iReady_BM_Accum,
    output logic [NC*($clog2(NP)+1+WV)-1:0]  oData_BM_Accum
);

    localparam int WA = $clog2(NP) + 1 + WV;
    localparam int CW = (NP > 1) ? $clog2(NP) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NP - 1);

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [NC*WA-1:0] acc_q, acc_d;
    logic [NC*WA-1:0] out_q, out_d;
    logic             valid_q, valid_d;
    logic [NC*WA-1:0] sum;
    logic             first, is_last, accept, drain;

    assign first   = (cnt_q == '0);
    assign is_last = (cnt_q == CNT_LAST);
    assign accept  = iValid_AS_Term && oReady_AS_Term;
    assign drain   = valid_q && iReady_BM_Accum;

    // Only the last term of a batch can be blocked by a pending result.
    assign oReady_AS_Term = !(is_last && valid_q && !iReady_BM_Accum);

    for (genvar i = 0; i < NC; i++) begin : g_lane
        logic [WA-1:0] base;
        logic [WA-1:0] ext;
        assign ext  = {{(WA-WV){iData_AS_Term[i*WV+WV-1]}},
                       iData_AS_Term[i*WV +: WV]};
        assign base = first ? '0 : acc_q[i*WA +: WA];
        assign sum[i*WA +: WA] = base + ext;
    end

    always_comb begin
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        out_d   = out_q;
        valid_d = valid_q;
        if (drain) begin
            valid_d = 1'b0;
        end
        if (accept) begin
            if (is_last) begin
                out_d   = sum;
                valid_d = 1'b1;
                cnt_d   = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            cnt_q   <= '0;
            acc_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign oValid_BM_Accum = valid_q;
    assign oData_BM_Accum  = out_q;

endmodule
